// File: rtl/mure_block_builder.sv
// Groups consecutive retired uops into E-Trace instruction blocks for the trace encoder.
// Latency: a block appears on block_valid_o one cycle after its closing event. Backpressure: the uop FIFO stalls while the output register is held.
package mure_pkg;
    parameter int unsigned XLEN        = 32;
    parameter int unsigned ITYPE_LEN   = 3;
    parameter int unsigned PRIV_LEN    = 2;
    parameter int unsigned IRETIRE_LEN = 14;

    typedef enum logic [ITYPE_LEN-1:0] {
        STD       = 3'd0,
        EXC       = 3'd1,
        INT       = 3'd2,
        ERET      = 3'd3,
        NT_BR     = 3'd4,
        TB        = 3'd5,
        UNINF_JMP = 3'd6
    } itype_e;
endpackage

module mure_block_builder #(
    parameter int unsigned XLEN        = mure_pkg::XLEN,
    parameter int unsigned ITYPE_LEN   = mure_pkg::ITYPE_LEN,
    parameter int unsigned PRIV_LEN    = mure_pkg::PRIV_LEN,
    parameter int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   uop_valid_i,
    output logic                   uop_ready_o,
    input  logic [XLEN-1:0]        uop_pc_i,
    input  logic [ITYPE_LEN-1:0]   uop_itype_i,
    input  logic                   uop_compressed_i,
    input  logic [PRIV_LEN-1:0]    uop_priv_i,
    input  logic                   flush_i,
    output logic                   block_valid_o,
    input  logic                   block_ready_i,
    output logic [XLEN-1:0]        iaddr_o,
    output logic [IRETIRE_LEN-1:0] iretire_o,
    output logic                   ilastsize_o,
    output logic [ITYPE_LEN-1:0]   itype_o,
    output logic [PRIV_LEN-1:0]    priv_o
);
    typedef enum logic {IDLE, COUNT} state_e;

    // STD is encoded as zero in itype_e; anything else closes a block.
    localparam logic [ITYPE_LEN-1:0] ITYPE_STD = '0;
    localparam logic [IRETIRE_LEN:0] IRET_MAX  = {1'b0, {IRETIRE_LEN{1'b1}}};

    state_e                 state_q;
    logic [XLEN-1:0]        acc_iaddr_q;
    logic [IRETIRE_LEN-1:0] acc_iretire_q;
    logic [PRIV_LEN-1:0]    acc_priv_q;
    logic                   acc_lastsize_q;

    logic                   block_valid_q;
    logic [XLEN-1:0]        iaddr_q;
    logic [IRETIRE_LEN-1:0] iretire_q;
    logic                   ilastsize_q;
    logic [ITYPE_LEN-1:0]   itype_q;
    logic [PRIV_LEN-1:0]    priv_q;

    logic [IRETIRE_LEN:0]   uop_size;
    logic [IRETIRE_LEN:0]   iretire_sum_d;
    logic                   out_free;
    logic                   close_early;
    logic                   accept;
    logic                   uop_is_std;

    assign uop_size      = uop_compressed_i ? (IRETIRE_LEN+1)'(1) : (IRETIRE_LEN+1)'(2);
    assign iretire_sum_d = {1'b0, acc_iretire_q} + uop_size;
    assign out_free      = !block_valid_q || block_ready_i;
    // A uop that cannot join the open block forces it closed first and waits at the FIFO head.
    assign close_early   = (state_q == COUNT) && uop_valid_i &&
                           ((uop_priv_i != acc_priv_q) || (iretire_sum_d > IRET_MAX));
    assign uop_ready_o   = out_free && !flush_i && !close_early;
    assign accept        = uop_valid_i && uop_ready_o;
    assign uop_is_std    = (uop_itype_i == ITYPE_STD);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            acc_iaddr_q    <= '0;
            acc_iretire_q  <= '0;
            acc_priv_q     <= '0;
            acc_lastsize_q <= 1'b0;
            block_valid_q  <= 1'b0;
            iaddr_q        <= '0;
            iretire_q      <= '0;
            ilastsize_q    <= 1'b0;
            itype_q        <= '0;
            priv_q         <= '0;
        end else begin
            if (block_valid_q && block_ready_i) begin
                block_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_iaddr_q    <= uop_pc_i;
                        acc_iretire_q  <= uop_size[IRETIRE_LEN-1:0];
                        acc_priv_q     <= uop_priv_i;
                        acc_lastsize_q <= !uop_compressed_i;
                        if (!uop_is_std) begin
                            block_valid_q <= 1'b1;
                            iaddr_q       <= uop_pc_i;
                            iretire_q     <= uop_size[IRETIRE_LEN-1:0];
                            ilastsize_q   <= !uop_compressed_i;
                            itype_q       <= uop_itype_i;
                            priv_q        <= uop_priv_i;
                        end else begin
                            state_q <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if ((flush_i || close_early) && out_free) begin
                        block_valid_q <= 1'b1;
                        iaddr_q       <= acc_iaddr_q;
                        iretire_q     <= acc_iretire_q;
                        ilastsize_q   <= acc_lastsize_q;
                        itype_q       <= ITYPE_STD;
                        priv_q        <= acc_priv_q;
                        state_q       <= IDLE;
                    end else if (accept) begin
                        acc_iretire_q  <= iretire_sum_d[IRETIRE_LEN-1:0];
                        acc_lastsize_q <= !uop_compressed_i;
                        if (!uop_is_std) begin
                            block_valid_q <= 1'b1;
                            iaddr_q       <= acc_iaddr_q;
                            iretire_q     <= iretire_sum_d[IRETIRE_LEN-1:0];
                            ilastsize_q   <= !uop_compressed_i;
                            itype_q       <= uop_itype_i;
                            priv_q        <= acc_priv_q;
                            state_q       <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign block_valid_o = block_valid_q;
    assign iaddr_o       = iaddr_q;
    assign iretire_o     = iretire_q;
    assign ilastsize_o   = ilastsize_q;
    assign itype_o       = itype_q;
    assign priv_o        = priv_q;
endmodule

// File: tb/tb_mure_block_builder.sv
// Directed and randomized checks of mure_block_builder against a block-level reference model.
module tb_mure_block_builder;
    localparam int XL = 32, IL = 3, PL = 2, RL = 4;
    localparam int IRET_MAX = (1 << RL) - 1;

    typedef struct {
        logic [XL-1:0] iaddr;
        int            iret;
        bit            last;
        logic [IL-1:0] itype;
        logic [PL-1:0] priv;
    } blk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uop_valid = 1'b0;
    logic          uop_ready;
    logic [XL-1:0] uop_pc = '0;
    logic [IL-1:0] uop_itype = '0;
    logic          uop_comp = 1'b0;
    logic [PL-1:0] uop_priv = '0;
    logic          flush = 1'b0;
    logic          block_valid;
    logic          block_ready = 1'b1;
    logic [XL-1:0] iaddr;
    logic [RL-1:0] iretire;
    logic          ilastsize;
    logic [IL-1:0] itype;
    logic [PL-1:0] priv;

    int   n_chk = 0, n_fail = 0;
    bit   m_open = 0, m_vld = 0, took = 0;
    blk_t m_acc, m_out;
    int   hs_count = 0;
    blk_t hs_blk;

    always #5 clk = ~clk;

    mure_block_builder #(.XLEN(XL), .ITYPE_LEN(IL), .PRIV_LEN(PL), .IRETIRE_LEN(RL)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .uop_valid_i(uop_valid), .uop_ready_o(uop_ready),
        .uop_pc_i(uop_pc), .uop_itype_i(uop_itype),
        .uop_compressed_i(uop_comp), .uop_priv_i(uop_priv),
        .flush_i(flush),
        .block_valid_o(block_valid), .block_ready_i(block_ready),
        .iaddr_o(iaddr), .iretire_o(iretire), .ilastsize_o(ilastsize),
        .itype_o(itype), .priv_o(priv)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic emit(input logic [IL-1:0] ity);
        m_out       = m_acc;
        m_out.itype = ity;
        m_vld       = 1;
        m_open      = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        int sz;
        bit of, early, er;
        @(negedge clk);
        took = 0;
        if (!rst_n) begin
            m_open = 0;
            m_vld  = 0;
        end else begin
            sz    = uop_comp ? 1 : 2;
            of    = !m_vld || block_ready;
            early = m_open && uop_valid && (uop_priv != m_acc.priv || m_acc.iret + sz > IRET_MAX);
            er    = of && !flush && !early;
            chk("uop_ready", uop_ready, er);
            chk("block_valid", block_valid, m_vld);
            if (m_vld) begin
                chk("iaddr", iaddr, m_out.iaddr);
                chk("iretire", iretire, m_out.iret);
                chk("ilastsize", ilastsize, m_out.last);
                chk("itype", itype, m_out.itype);
                chk("priv", priv, m_out.priv);
            end
            if (block_valid && block_ready) begin
                hs_count++;
                hs_blk.iaddr = iaddr;
                hs_blk.iret  = int'(iretire);
                hs_blk.last  = ilastsize;
                hs_blk.itype = itype;
                hs_blk.priv  = priv;
            end
            took = uop_valid && er;
            if (m_vld && block_ready) m_vld = 0;
            if (m_open && flush && of) begin
                emit('0);
            end else if (early && of) begin
                emit('0);
            end else if (took) begin
                if (!m_open) begin
                    m_acc.iaddr = uop_pc;
                    m_acc.iret  = sz;
                    m_acc.priv  = uop_priv;
                end else begin
                    m_acc.iret += sz;
                end
                m_acc.last = !uop_comp;
                if (uop_itype != 0) emit(uop_itype);
                else m_open = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [XL-1:0] pc, input logic [IL-1:0] ity, input bit comp, input logic [PL-1:0] pv);
        uop_valid = 1; uop_pc = pc; uop_itype = ity; uop_comp = comp; uop_priv = pv;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (took) break;
        end
        if (!took) chk("send_timeout", 0, 1);
        uop_valid = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        tick();
        flush = 0;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 0; uop_valid = 0; flush = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    initial begin
        int hs0;
        bit have;
        logic [XL-1:0] next_pc;

        do_reset();
        chk("rst_valid", block_valid, 0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_iretire", iretire, 0);
        chk("rst_ilastsize", ilastsize, 0);
        chk("rst_itype", itype, 0);
        chk("rst_priv", priv, 0);

        // Three uops closing on a taken branch.
        send(32'h8000_0000, 3'd0, 0, 2'd3);
        send(32'h8000_0004, 3'd0, 1, 2'd3);
        send(32'h8000_0006, 3'd5, 0, 2'd3);
        chk("t1_valid", block_valid, 1);
        chk("t1_iaddr", iaddr, 32'h8000_0000);
        chk("t1_iretire", iretire, 5);
        chk("t1_ilastsize", ilastsize, 1);
        chk("t1_itype", itype, 5);
        chk("t1_priv", priv, 3);

        // Single exception uop from IDLE.
        send(32'h1000, 3'd1, 1, 2'd3);
        chk("t2_iaddr", iaddr, 32'h1000);
        chk("t2_iretire", iretire, 1);
        chk("t2_ilastsize", ilastsize, 0);
        chk("t2_itype", itype, 1);

        // Privilege change closes the open block early.
        send(32'h2000, 3'd0, 0, 2'd3);
        send(32'h2004, 3'd0, 0, 2'd3);
        send(32'h2008, 3'd0, 0, 2'd0);
        chk("t3_iretire", hs_blk.iret, 4);
        chk("t3_priv", hs_blk.priv, 3);
        chk("t3_itype", hs_blk.itype, 0);
        do_flush();
        chk("t3_new_iaddr", hs_blk.iaddr, 32'h2008);
        chk("t3_new_priv", hs_blk.priv, 0);

        // iretire saturation: the 8th 32-bit uop would exceed 15 half-words.
        for (int i = 0; i < 8; i++) send(32'h3000 + 4 * i, 3'd0, 0, 2'd1);
        chk("t4_iretire", hs_blk.iret, 14);
        chk("t4_itype", hs_blk.itype, 0);
        do_flush();
        chk("t4_new_iretire", hs_blk.iret, 2);
        chk("t4_new_iaddr", hs_blk.iaddr, 32'h301c);

        // Output backpressure holds everything stable.
        block_ready = 0;
        send(32'h4000, 3'd0, 0, 2'd3);
        send(32'h4004, 3'd5, 0, 2'd3);
        uop_valid = 1; uop_pc = 32'h4008; uop_itype = 3'd1; uop_comp = 0; uop_priv = 2'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_hold_iaddr", iaddr, 32'h4000);
            chk("t5_hold_ready", uop_ready, 0);
        end
        block_ready = 1;
        tick();
        uop_valid = 0;
        chk("t5_second_valid", block_valid, 1);
        chk("t5_second_iaddr", iaddr, 32'h4008);
        chk("t5_second_itype", itype, 1);
        tick();

        // Flush closes an open block; reset discards one.
        send(32'h5000, 3'd0, 0, 2'd3);
        send(32'h5004, 3'd0, 0, 2'd3);
        flush = 1;
        tick();
        chk("t6_flush_ready", uop_ready, 0);
        flush = 0;
        tick();
        chk("t6_iretire", hs_blk.iret, 4);
        chk("t6_itype", hs_blk.itype, 0);
        send(32'h6000, 3'd0, 0, 2'd3);
        hs0 = hs_count;
        do_reset();
        chk("t6_rst_valid", block_valid, 0);
        send(32'h7000, 3'd1, 1, 2'd2);
        chk("t6_fresh_iaddr", iaddr, 32'h7000);
        chk("t6_fresh_iretire", iretire, 1);
        chk("t6_no_block", hs_count, hs0);

        // Randomized traffic; the FIFO head is held until it is popped.
        have = 0;
        next_pc = 32'h8000_0000;
        for (int c = 0; c < 4000; c++) begin
            if (!have && $urandom_range(0, 9) < 8) begin
                have = 1;
                uop_pc    = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hffff_fffe) : next_pc;
                uop_comp  = $urandom_range(0, 1);
                uop_itype = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 6));
                if ($urandom_range(0, 9) == 0) uop_priv = 2'($urandom_range(0, 3));
                next_pc   = uop_pc + (uop_comp ? 2 : 4);
            end
            uop_valid   = have;
            flush       = ($urandom_range(0, 19) == 0);
            block_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                have = 0;
            end else begin
                tick();
                if (took) have = 0;
            end
        end
        uop_valid = 0; flush = 0; block_ready = 1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/mure_block_builder.md
Name: mure_block_builder

Overview:
- Sits directly downstream of the uop FIFO in the CVA6 trace connector.
- Consumes uop entries (pc, itype, compressed, priv) one at a time and groups consecutive retired instructions into E-Trace instruction blocks.
- Each block carries iaddr, iretire, ilastsize, itype and priv, and is handed to the trace encoder over a valid/ready interface.

Parameters:
- XLEN, mure_pkg::XLEN, PC/iaddr width.
- ITYPE_LEN, mure_pkg::ITYPE_LEN, itype width.
- PRIV_LEN, mure_pkg::PRIV_LEN, privilege width.
- IRETIRE_LEN, mure_pkg::IRETIRE_LEN, iretire counter width (counts half-words).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- uop_valid_i  in  1  FIFO head valid
- uop_ready_o  out  1  pop FIFO head
- uop_pc_i  in  XLEN  instruction PC
- uop_itype_i  in  ITYPE_LEN  itype_e of instruction
- uop_compressed_i  in  1  1 = 16-bit instruction
- uop_priv_i  in  PRIV_LEN  privilege of instruction
- flush_i  in  1  close open block (trace stop)
- block_valid_o  out  1  block available
- block_ready_i  in  1  encoder accepts block
- iaddr_o  out  XLEN  PC of first instruction in block
- iretire_o  out  IRETIRE_LEN  half-words retired in block
- ilastsize_o  out  1  1 = last instruction 32-bit, 0 = 16-bit
- itype_o  out  ITYPE_LEN  itype of last instruction, or STD if closed early
- priv_o  out  PRIV_LEN  block privilege

Behaviour:
- All state is registered and uses the synchronous active-low reset. On reset: state=IDLE, block_valid_o=0, iaddr_o/iretire_o/ilastsize_o/itype_o/priv_o=0, accumulator cleared. Reset mid-COUNT discards the open block; nothing is emitted.
- Definitions:
  - size = compressed ? 1 : 2 (half-words).
  - accept = uop_valid_i && uop_ready_o.
  - out_free = !block_valid_o || block_ready_i.
- Output register:
  - Set when a block closes.
  - Holds stable while block_valid_o && !block_ready_i.
  - block_valid_o clears after a handshake unless a new block closes in the same cycle; back-to-back blocks at 1/cycle.
- uop_ready_o = out_free && !flush_i && !close_early.
  - close_early = state==COUNT && uop_valid_i && (uop_priv_i != acc_priv || acc_iretire + size > 2^IRETIRE_LEN-1).
- State IDLE, on accept:
  - acc_iaddr=pc, acc_iretire=size, acc_priv=priv.
  - If itype != STD: emit block immediately (iretire=size, itype=uop itype, ilastsize=!compressed) and stay IDLE.
  - Else go to COUNT.
- State COUNT:
  - If flush_i && out_free: emit accumulator with itype=STD, ilastsize of last accepted uop; go to IDLE. No uop is consumed that cycle.
  - Else if close_early && out_free: emit accumulator with itype=STD; go to IDLE. The uop stays at the FIFO head and is accepted next cycle as the first instruction of a new block.
  - Else on accept:
    - acc_iretire += size.
    - If itype != STD: emit block (itype=uop itype, ilastsize=!compressed); go to IDLE.
    - Else stay in COUNT.
- flush_i in IDLE: no effect besides holding uop_ready_o=0.
- Emission latency: block_valid_o rises the cycle after the closing event.
- Sum width: compute at IRETIRE_LEN+1 bits; overflow never wraps because of the close_early check.
- Backpressure: while !out_free, no uop is consumed and no state changes; the accumulator is preserved.

Test Plan:
- Uops (0x80000000,STD,32b), (0x80000004,STD,16b), (0x80000006,TB,32b), priv=3, ready=1 -> one block: iaddr=0x80000000, iretire=5, ilastsize=1, itype=TB, priv=3, valid one cycle after third accept.
- IDLE, single (0x1000,EXC,16b) -> block: iaddr=0x1000, iretire=1, ilastsize=0, itype=EXC; state stays IDLE.
- Two STD 32b uops priv=3, then STD 32b priv=0 at 0x2008 -> third uop sees ready=0 for one cycle; block iretire=4, priv=3, itype=STD emitted; third uop then starts a new block with iaddr=0x2008, priv=0.
- IRETIRE_LEN=4, eight STD 32b uops -> first block iretire=14, itype=STD (7 instrs); 8th uop opens a new block with iretire=2.
- block_ready_i=0 while block_valid_o=1 and a second block is ready to close -> uop_ready_o=0; all outputs stable for 10 cycles; after ready=1, first block handshakes and second emits the next cycle.
- Two STD uops, then flush_i=1 -> block iretire=4, itype=STD; uop_ready_o=0 while flush_i=1. Separately, rst_ni=0 mid-COUNT -> block_valid_o=0, no block emitted, next uop starts fresh.
